// File: rtl/tinyqv_slice_alu.sv
// Multi-cycle tinyQV ALU: SLICE_W bits per cycle for arithmetic/logic/compare,
// one bit per cycle for shifts. One op in flight; done pulses when d/cmp_res are valid.
module tinyqv_slice_alu #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] d,
  output logic              cmp_res
);

  localparam int NSL = DATA_W / SLICE_W;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int SW  = $clog2(DATA_W);
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011, OP_AND = 4'b0111, OP_OR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0100, OP_EQ = 4'b1100, OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0101, OP_SRA = 4'b1101;

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ARITH | one slice per edge, LSB slice first, carry/eq chained
  // S_SHIFT | one bit per edge until the shift count is exhausted
  typedef enum logic [1:0] {S_IDLE, S_ARITH, S_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, d_q, d_d, work_q, work_d;
  logic [KW-1:0]       k_q, k_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                cy_q, cy_d, eq_q, eq_d, done_q, done_d, cmp_q, cmp_d;

  logic [SLICE_W-1:0]  a_k, b_k, bx_k, res_k;
  logic [SLICE_W:0]    sum_k;
  logic                inv_b, eq_k, lt_s, lt_u;
  logic [DATA_W-1:0]   shifted;

  function automatic logic op_inverts_b(input logic [3:0] o);
    return (o == OP_SUB) || (o == OP_SLT) || (o == OP_SLTU);
  endfunction

  function automatic logic op_is_shift(input logic [3:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    work_d  = work_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    eq_d    = eq_q;
    cmp_d   = cmp_q;
    done_d  = 1'b0;

    a_k   = a_q[int'(k_q)*SLICE_W +: SLICE_W];
    b_k   = b_q[int'(k_q)*SLICE_W +: SLICE_W];
    inv_b = op_inverts_b(op_q);
    bx_k  = inv_b ? ~b_k : b_k;
    sum_k = {1'b0, a_k} + {1'b0, bx_k} + {{SLICE_W{1'b0}}, cy_q};
    eq_k  = (a_k == b_k);
    lt_u  = ~sum_k[SLICE_W];
    // Signed less-than: sign of the difference corrected for overflow collapses to this.
    lt_s  = a_k[SLICE_W-1] ^ bx_k[SLICE_W-1] ^ sum_k[SLICE_W];

    case (op_q)
      OP_ADD, OP_SUB: res_k = sum_k[SLICE_W-1:0];
      OP_AND:         res_k = a_k & b_k;
      OP_OR:          res_k = a_k | b_k;
      OP_XOR:         res_k = a_k ^ b_k;
      default:        res_k = '0;
    endcase

    case (op_q)
      OP_SLL:  shifted = work_q << 1;
      OP_SRL:  shifted = work_q >> 1;
      OP_SRA:  shifted = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
      default: shifted = work_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          d_d     = '0;
          cmp_d   = 1'b0;
          k_d     = '0;
          cy_d    = op_inverts_b(op);
          eq_d    = 1'b1;
          cnt_d   = b[SW-1:0];
          work_d  = a;
          state_d = op_is_shift(op) ? S_SHIFT : S_ARITH;
        end
      end
      S_ARITH: begin
        d_d[int'(k_q)*SLICE_W +: SLICE_W] = res_k;
        cy_d = sum_k[SLICE_W];
        eq_d = eq_q & eq_k;
        k_d  = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_SLT:  cmp_d = lt_s;
            OP_SLTU: cmp_d = lt_u;
            OP_EQ:   cmp_d = eq_q & eq_k;
            default: cmp_d = 1'b0;
          endcase
          if (op_q == OP_SLT || op_q == OP_SLTU || op_q == OP_EQ) begin
            d_d = DATA_W'(cmp_d);
          end
        end
      end
      S_SHIFT: begin
        // Finishing on the count==1 edge keeps latency at max(shamt, 1).
        if (cnt_q == '0) begin
          d_d     = work_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == SW'(1)) begin
          d_d     = shifted;
          work_d  = shifted;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          work_d = shifted;
          cnt_d  = cnt_q - SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      work_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      eq_q    <= 1'b0;
      cmp_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      work_q  <= work_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      eq_q    <= eq_d;
      cmp_q   <= cmp_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign d       = d_q;
  assign cmp_res = cmp_q;

endmodule
